// File: rtl/lc3_memio_pkg.sv
// Shared definitions for the LC-3 memory/I-O stage: device register map,
// controller state encoding and status-register bit positions.
package lc3_memio_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Only the five listed addresses are devices; the rest of xFE00-xFFFF is RAM.
  function automatic logic is_dev(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) || (a == DSR_ADDR) ||
           (a == DDR_ADDR)  || (a == MCR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Memory-mapped keyboard/display/machine-control registers, their
// handshakes and the interrupt requests derived from them.
module lc3_io_regs
  import lc3_memio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        acc,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [1:0]  wr_flags,
  input  logic [7:0]  wr_char,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready,
  output logic        kb_int,
  output logic        dd_int,
  output logic        run
);

  logic       kb_rdy;
  logic       kb_ie;
  logic [7:0] kbdr;
  logic       ds_rdy;
  logic       ds_ie;
  logic       mcr_run;

  logic kb_rd;
  logic kb_accept;
  logic dd_done;
  logic ddr_wr;

  assign kb_rd     = acc && !we && (addr == KBDR_ADDR);
  assign kb_accept = kb_valid && !kb_rdy;
  assign dd_done   = dd_valid && dd_ready;
  // A completing display handshake is seen only on the next edge, so a
  // coincident DDR store still sees DSR not ready and is dropped.
  assign ddr_wr    = acc && we && (addr == DDR_ADDR) && ds_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kb_rdy   <= 1'b0;
      kb_ie    <= 1'b0;
      kbdr     <= 8'h00;
      ds_rdy   <= 1'b1;
      ds_ie    <= 1'b0;
      mcr_run  <= 1'b1;
      dd_valid <= 1'b0;
      dd_data  <= 8'h00;
    end else begin
      if (kb_rd) kb_rdy <= 1'b0;
      if (kb_accept) begin
        kbdr   <= kb_data;
        kb_rdy <= 1'b1;
      end
      if (dd_done) begin
        dd_valid <= 1'b0;
        ds_rdy   <= 1'b1;
      end
      if (ddr_wr) begin
        dd_data  <= wr_char;
        dd_valid <= 1'b1;
        ds_rdy   <= 1'b0;
      end
      if (acc && we) begin
        case (addr)
          KBSR_ADDR: kb_ie   <= wr_flags[0];
          DSR_ADDR:  ds_ie   <= wr_flags[0];
          MCR_ADDR:  mcr_run <= wr_flags[1];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      KBSR_ADDR: begin
        rdata[READY_BIT] = kb_rdy;
        rdata[IE_BIT]    = kb_ie;
      end
      KBDR_ADDR: rdata = {8'h00, kbdr};
      DSR_ADDR: begin
        rdata[READY_BIT] = ds_rdy;
        rdata[IE_BIT]    = ds_ie;
      end
      DDR_ADDR:  rdata = {8'h00, dd_data};
      MCR_ADDR:  rdata[READY_BIT] = mcr_run;
      default:   rdata = 16'h0000;
    endcase
  end

  assign kb_ready = !kb_rdy;
  assign kb_int   = kb_rdy && kb_ie;
  assign dd_int   = ds_rdy && ds_ie;
  assign run      = mcr_run;

endmodule

// File: rtl/lc3_memio.sv
// LC-3 memory/I-O stage: turns MAR/MDR requests into synchronous RAM
// accesses or device register accesses and returns a one-cycle ready.
module lc3_memio
  import lc3_memio_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        mem_r,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready,
  output logic        kb_int,
  output logic        dd_int,
  output logic        run,
  output logic [1:0]  fsm_state
);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic        dev_acc;
  logic [15:0] io_rdata;

  // Device accesses complete on the accepting edge, using the live request.
  assign dev_acc = (state == IDLE) && mem_en && is_dev(mar);

  lc3_io_regs u_io_regs (
    .clk      (clk),
    .reset    (reset),
    .acc      (dev_acc),
    .we       (mem_we),
    .addr     (mar),
    .wr_flags (mdr_in[15:14]),
    .wr_char  (mdr_in[7:0]),
    .rdata    (io_rdata),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .kb_ready (kb_ready),
    .dd_valid (dd_valid),
    .dd_data  (dd_data),
    .dd_ready (dd_ready),
    .kb_int   (kb_int),
    .dd_int   (dd_int),
    .run      (run)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mem_en) state_nx = is_dev(mar) ? DONE : ACC;
      ACC:  state_nx = WAIT;
      WAIT: if (cnt == 4'd0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      mdr_out <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            addr_q  <= mar;
            wdata_q <= mdr_in;
            we_q    <= mem_we;
            if (is_dev(mar) && !mem_we) mdr_out <= io_rdata;
          end
        end
        ACC: cnt <= 4'(WAIT_CYC - 1);
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!we_q) mdr_out <= ram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_r     = (state == DONE);
  assign ram_en    = (state == ACC);
  assign ram_we    = (state == ACC) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_lc3_memio.sv
// Directed bench for lc3_memio: the driver queues the expected read data and
// ready cycle of each access; a monitor checks them whenever mem_r pulses.
module tb_lc3_memio;
  import lc3_memio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr_in = 16'h0000;
  logic [15:0] mdr_out;
  logic        mem_r;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0000;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ready;
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready = 1'b0;
  logic        kb_int;
  logic        dd_int;
  logic        run;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ram_en_cnt = 0;
  int mem_r_cnt = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] last_load = 16'h0000;
  logic [15:0] ram_mem [256];

  lc3_memio #(.WAIT_CYC(2)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we), .mar(mar),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_r(mem_r), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .kb_valid(kb_valid), .kb_data(kb_data),
    .kb_ready(kb_ready), .dd_valid(dd_valid), .dd_data(dd_data),
    .dd_ready(dd_ready), .kb_int(kb_int), .dd_int(dd_int), .run(run),
    .fsm_state(fsm_state)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // synchronous RAM: read data valid the cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (ram_en) ram_en_cnt++;
    if (mem_r) begin
      mem_r_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_r: mem_r at cycle %0d with nothing pending", cyc);
      end else begin
        check("mdr_out", mdr_out, exp_q.pop_front());
        check("mem_r_cycle", 16'(cyc), 16'(exp_cyc_q.pop_front()));
      end
    end
  end

  // one access; lat is the mem_r cycle counted from the accepting edge
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input int lat);
    int  r0;
    bit  seen;
    seen = 1'b0;
    @(negedge clk);
    r0 = ram_en_cnt;
    mem_en = 1'b1;
    mem_we = we;
    mar    = addr;
    mdr_in = wdata;
    if (!we) last_load = exp_rd;
    exp_q.push_back(last_load);
    exp_cyc_q.push_back(cyc + lat);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_r;
    end
    mem_en = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL mem_r_timeout: addr %h got no ready, required one within 20 cycles", addr);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    check("ram_en_pulses", 16'(ram_en_cnt - r0), (lat > 1) ? 16'd1 : 16'd0);
  endtask

  task automatic key(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1;
    kb_data  = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int m0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_r", 16'(mem_r), 16'd0);
    check("rst_run", 16'(run), 16'd1);
    check("rst_kb_ready", 16'(kb_ready), 16'd1);
    check("rst_dd_valid", 16'(dd_valid), 16'd0);
    check("rst_mdr_out", mdr_out, 16'h0000);
    check("rst_ram_en", 16'(ram_en), 16'd0);
    check("rst_ram_addr", ram_addr, 16'h0000);
    check("rst_ints", {14'd0, kb_int, dd_int}, 16'd0);
    check("rst_state", 16'(fsm_state), 16'(IDLE));

    access(1'b0, 16'hFFFE, 16'h0000, 16'h8000, 1);

    // RAM path, including an unlisted address in the device page
    access(1'b1, 16'h3000, 16'h1234, 16'h0000, 4);
    access(1'b0, 16'h3000, 16'h0000, 16'h1234, 4);
    access(1'b1, 16'hFE08, 16'h5555, 16'h0000, 4);
    access(1'b0, 16'hFE08, 16'h0000, 16'h5555, 4);

    // keyboard
    key(8'h41);
    check("kb_ready_after_key", 16'(kb_ready), 16'd0);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'h8000, 1);
    access(1'b0, KBDR_ADDR, 16'h0000, 16'h0041, 1);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'h0000, 1);
    check("kb_ready_after_read", 16'(kb_ready), 16'd1);

    // display
    access(1'b1, DDR_ADDR, 16'h0048, 16'h0000, 1);
    check("dd_valid_set", 16'(dd_valid), 16'd1);
    check("dd_data_48", 16'(dd_data), 16'h0048);
    access(1'b0, DSR_ADDR, 16'h0000, 16'h0000, 1);
    access(1'b1, DDR_ADDR, 16'h0049, 16'h0000, 1);
    check("dd_data_dropped", 16'(dd_data), 16'h0048);
    access(1'b0, DDR_ADDR, 16'h0000, 16'h0048, 1);
    @(negedge clk);
    dd_ready = 1'b1;
    @(negedge clk);
    dd_ready = 1'b0;
    check("dd_valid_cleared", 16'(dd_valid), 16'd0);
    access(1'b0, DSR_ADDR, 16'h0000, 16'h8000, 1);

    // interrupts
    access(1'b1, KBSR_ADDR, 16'h4000, 16'h0000, 1);
    check("kb_int_no_key", 16'(kb_int), 16'd0);
    key(8'h42);
    check("kb_int_set", 16'(kb_int), 16'd1);
    access(1'b0, KBDR_ADDR, 16'h0000, 16'h0042, 1);
    check("kb_int_cleared", 16'(kb_int), 16'd0);
    access(1'b1, DSR_ADDR, 16'h4000, 16'h0000, 1);
    check("dd_int_set", 16'(dd_int), 16'd1);
    access(1'b0, DSR_ADDR, 16'h0000, 16'hC000, 1);

    // KBDR load on the same edge a new key is offered
    key(8'h43);
    kb_valid = 1'b1;
    kb_data  = 8'h44;
    access(1'b0, KBDR_ADDR, 16'h0000, 16'h0043, 1);
    @(negedge clk);
    kb_valid = 1'b0;
    check("kb_ready_second_key", 16'(kb_ready), 16'd0);
    access(1'b0, KBSR_ADDR, 16'h0000, 16'hC000, 1);
    access(1'b0, KBDR_ADDR, 16'h0000, 16'h0044, 1);

    // DDR store on the same edge as dd_ready
    access(1'b1, DDR_ADDR, 16'h0050, 16'h0000, 1);
    check("dd_int_busy", 16'(dd_int), 16'd0);
    fork
      access(1'b1, DDR_ADDR, 16'h0051, 16'h0000, 1);
      begin
        @(negedge clk);
        dd_ready = 1'b1;
        @(negedge clk);
        dd_ready = 1'b0;
      end
    join
    check("dd_valid_same_edge", 16'(dd_valid), 16'd0);
    access(1'b0, DSR_ADDR, 16'h0000, 16'hC000, 1);
    access(1'b0, DDR_ADDR, 16'h0000, 16'h0050, 1);

    // MCR
    access(1'b1, MCR_ADDR, 16'h0000, 16'h0000, 1);
    check("run_cleared", 16'(run), 16'd0);
    access(1'b0, MCR_ADDR, 16'h0000, 16'h0000, 1);
    access(1'b1, MCR_ADDR, 16'hFFFF, 16'h0000, 1);
    check("run_set", 16'(run), 16'd1);
    access(1'b0, MCR_ADDR, 16'h0000, 16'h8000, 1);

    // reset during WAIT
    @(negedge clk);
    m0 = mem_r_cnt;
    r0 = ram_en_cnt;
    mem_en = 1'b1;
    mem_we = 1'b0;
    mar    = 16'h3000;
    @(negedge clk);
    check("abort_acc_ram_en", 16'(ram_en), 16'd1);
    @(negedge clk);
    check("abort_in_wait", 16'(fsm_state), 16'(WAIT));
    reset = 1'b1;
    #1;
    check("abort_ram_en", 16'(ram_en), 16'd0);
    check("abort_state", 16'(fsm_state), 16'(IDLE));
    mem_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_mem_r", 16'(mem_r_cnt - m0), 16'd0);
    check("abort_one_ram_en", 16'(ram_en_cnt - r0), 16'd1);
    check("abort_mdr_out", mdr_out, 16'h0000);
    last_load = 16'h0000;
    access(1'b0, 16'h3000, 16'h0000, 16'h1234, 4);

    repeat (3) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_memio.md
# lc3_memio

Memory and I/O interface stage directly downstream of the LC-3 datapath's MAR/MDR path. It converts the datapath's memory requests into accesses on an external synchronous RAM or on the memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR). It returns read data together with the one-cycle ready pulse R that the datapath's control FSM waits on. It also produces the keyboard/display interrupt requests and the MCR run bit that gates the datapath clock enable.

## Interface
- WAIT_CYC, 2, RAM wait cycles after the RAM command (legal range 1..15).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_en  in  1  access request from the datapath; held high until mem_r.
- mem_we  in  1  1 = store, 0 = load; valid while mem_en is high.
- mar  in  16  access address.
- mdr_in  in  16  store data.
- mdr_out  out  16  load data; valid while mem_r is high and held afterwards.
- mem_r  out  1  ready; a one-cycle pulse per access.
- ram_en, ram_we  out  1 each  RAM command strobes.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data; valid the cycle after ram_en.
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  block can accept a keyboard character.
- dd_valid  out  1  display character pending.
- dd_data  out  8  display character.
- dd_ready  in  1  display consumed the character.
- kb_int, dd_int  out  1 each  interrupt requests.
- run  out  1  MCR[15], the datapath clock enable.

## Operation
- Address map: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR, xFFFE MCR. Every other address, including unlisted xFE00–xFFFF addresses, goes to RAM.
- FSM states: IDLE, ACC, WAIT, DONE.
- IDLE: if mem_en=1, latch mar, mem_we and mdr_in.
  - RAM address: go to ACC.
  - Device address: perform the register access on the same edge, capture the read value, and go to DONE.
- ACC: ram_en=1 for exactly one cycle; ram_we, ram_addr and ram_wdata come from the latched values. Then go to WAIT with the counter loaded to WAIT_CYC-1.
- WAIT: count down. On the edge where the count reaches 0, capture ram_rdata into mdr_out (loads only) and go to DONE.
- DONE: mem_r=1 for one cycle, then go to IDLE.
  - The datapath drops mem_en in the cycle after mem_r.
  - If mem_en is still high in IDLE, that is a new access.
- Stores leave mdr_out unchanged.
- KBSR: bit 15 is ready (read-only); bit 14 is IE (writable); all other bits read 0.
  - kb_ready = !KBSR[15].
  - When kb_valid & kb_ready: KBDR <= {8'h00, kb_data} and KBSR[15] <= 1.
  - A load of KBDR clears KBSR[15].
  - Stores to KBDR are ignored.
- DSR: bit 15 is ready (read-only); bit 14 is IE (writable).
  - A store to DDR when DSR[15]=1: dd_data <= mdr_in[7:0], dd_valid <= 1, DSR[15] <= 0.
  - A store to DDR when DSR[15]=0 is dropped; mem_r is still returned.
  - When dd_valid & dd_ready: dd_valid <= 0, DSR[15] <= 1.
  - A load of DDR returns {8'h00, dd_data}.
- MCR: bit 15 is read/write; all other bits read 0. run = MCR[15].
- kb_int = KBSR[15] & KBSR[14]; dd_int = DSR[15] & DSR[14].

## Timing
- Reset values:
  - Outputs: mem_r 0, mdr_out x0000, ram_en 0, ram_we 0, ram_addr x0000, ram_wdata x0000, kb_ready 1, dd_valid 0, dd_data x00, kb_int 0, dd_int 0, run 1.
  - Registers: KBSR x0000, KBDR x0000, DSR x8000, MCR x8000.
  - FSM: IDLE.
- RAM access latency: mem_r is high in cycle WAIT_CYC+2 after the accepting edge (cycle 1 = ACC). With the default WAIT_CYC, that is cycle 4.
- Device access latency: mem_r is high in the cycle immediately after the accepting edge.
- KBDR load on the same edge as kb_valid: no new character is accepted that cycle, because kb_ready is still 0. The character is accepted on the next edge if still offered.
- DDR store on the same edge as dd_ready: dd_ready completes the old character first. The store sees DSR[15]=0 and is dropped.
- Reset mid-access aborts the access:
  - No mem_r pulse.
  - ram_en is deasserted immediately.
  - A RAM write already issued stands.

## Structure
- Shared package/include holds:
  - device address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR);
  - FSM state encodings;
  - bit positions READY_BIT=15 and IE_BIT=14.
- One sub-module, lc3_io_regs, holds KBSR/KBDR/DSR/DDR/MCR, the keyboard/display handshakes and the interrupt outputs. The top level holds the FSM, the wait counter and the RAM port.

## Test plan
- Reset, then release: mem_r=0, run=1, kb_ready=1, dd_valid=0. A load of xFFFE returns x8000 with mem_r one cycle after acceptance.
- Store x1234 to x3000, then load x3000 (WAIT_CYC=2): each access gives exactly one ram_en pulse and mem_r in cycle 4. The load returns mdr_out=x1234.
- kb_valid with kb_data x41: kb_ready goes to 0. KBSR reads x8000, KBDR reads x0041, then KBSR reads x0000 and kb_ready=1.
- Store x0048 to xFE06: dd_valid=1, dd_data=x48, DSR reads x0000. A second store of x0049 is dropped. dd_ready for one cycle gives dd_valid=0 and DSR reads x8000.
- Store x4000 to KBSR, then a key arrives: kb_int=1. Loading KBDR drops kb_int to 0.
- Reset asserted during WAIT: mem_r never pulses, ram_en=0 and the FSM is IDLE. The next load completes normally.
